decode_stage_hz: RTL

Parametrised successor of the single-issue ID stage: register file, main control decode, sign extension and the ID/EX pipeline register. Adds load-use hazard detection with bubble insertion, external flush (branch taken) and hold (back-end stall), write-through register bypass, rs forwarding field, and illegal-opcode flagging. Sits between the IF/ID register and the execute stage.

---
 rtl/decode_stage_hz.sv | 139 +++++++++++++
 1 files changed

// File: rtl/decode_stage_hz.sv
// Instruction decode stage: register file with write-through bypass, main control decode,
// sign extension, load-use hazard detection and the ID/EX pipeline register.
module decode_stage_hz #(
    parameter int DATA_W    = 32,
    parameter int RA_W      = 5,
    parameter int IMM_W     = 16,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_reg_write,
    input  logic [RA_W-1:0]   wb_write_reg_location,
    input  logic [DATA_W-1:0] mem_wb_write_data,
    input  logic [31:0]       if_id_instr,
    input  logic [DATA_W-1:0] if_id_npc,
    input  logic              flush,
    input  logic              hold,
    output logic              stall_o,
    output logic              illegal_o,
    output logic [1:0]        id_ex_wb,
    output logic [2:0]        id_ex_mem,
    output logic [3:0]        id_ex_execute,
    output logic [DATA_W-1:0] id_ex_npc,
    output logic [DATA_W-1:0] id_ex_readdat1,
    output logic [DATA_W-1:0] id_ex_readdat2,
    output logic [DATA_W-1:0] id_ex_sign_ext,
    output logic [RA_W-1:0]   id_ex_instr_bits_25_21,
    output logic [RA_W-1:0]   id_ex_instr_bits_20_16,
    output logic [RA_W-1:0]   id_ex_instr_bits_15_11
);

    localparam int NREG = 1 << RA_W;

    function automatic logic [RA_W-1:0] fit_ra(input logic [4:0] f);
        logic [RA_W+4:0] t;
        t = {{RA_W{1'b0}}, f};
        return t[RA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        logic signed [IMM_W-1:0] s;
        s = imm;
        return DATA_W'(s);
    endfunction

    logic [DATA_W-1:0] rf_q [NREG];

    logic [RA_W-1:0]   rs_d, rt_d, rd_d;
    logic [DATA_W-1:0] rdat1_d, rdat2_d, sext_d;
    logic [1:0]        wb_d;
    logic [2:0]        mem_d;
    logic [3:0]        ex_d;
    logic              ill_d;
    logic              wr_live;

    logic [1:0]        wb_q;
    logic [2:0]        mem_q;
    logic [3:0]        ex_q;
    logic              ill_q;
    logic [DATA_W-1:0] npc_q, rdat1_q, rdat2_q, sext_q;
    logic [RA_W-1:0]   rs_q, rt_q, rd_q;

    assign rs_d    = fit_ra(if_id_instr[25:21]);
    assign rt_d    = fit_ra(if_id_instr[20:16]);
    assign rd_d    = fit_ra(if_id_instr[15:11]);
    assign sext_d  = sext_imm(if_id_instr[IMM_W-1:0]);
    assign wr_live = wb_reg_write && (wb_write_reg_location != '0);

    // Same-cycle write-back is forwarded so ID never sees a stale value.
    assign rdat1_d = (wr_live && wb_write_reg_location == rs_d) ? mem_wb_write_data : rf_q[rs_d];
    assign rdat2_d = (wr_live && wb_write_reg_location == rt_d) ? mem_wb_write_data : rf_q[rt_d];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wr_live) begin
            rf_q[wb_write_reg_location] <= mem_wb_write_data;
        end
    end

    always_comb begin
        wb_d  = 2'b00;
        mem_d = 3'b000;
        ex_d  = 4'b0000;
        ill_d = 1'b0;
        unique case (if_id_instr[31:26])
            6'b000000: begin wb_d = 2'b10; ex_d = 4'b1100; end
            6'b100011: begin wb_d = 2'b11; mem_d = 3'b010; ex_d = 4'b0001; end
            6'b101011: begin mem_d = 3'b001; ex_d = 4'b0001; end
            6'b000100: begin mem_d = 3'b100; ex_d = 4'b0010; end
            default:   ill_d = 1'b1;
        endcase
    end

    // A frozen back end cannot absorb a bubble, so hold suppresses the stall request.
    assign stall_o = HAZARD_EN && !hold && mem_q[1] && (rt_q != '0)
                     && ((rt_q == rs_d) || (rt_q == rt_d));

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q    <= '0;
            mem_q   <= '0;
            ex_q    <= '0;
            ill_q   <= 1'b0;
            npc_q   <= '0;
            rdat1_q <= '0;
            rdat2_q <= '0;
            sext_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else if (flush || !hold) begin
            wb_q    <= (flush || stall_o) ? 2'b00   : wb_d;
            mem_q   <= (flush || stall_o) ? 3'b000  : mem_d;
            ex_q    <= (flush || stall_o) ? 4'b0000 : ex_d;
            ill_q   <= (flush || stall_o) ? 1'b0    : ill_d;
            npc_q   <= if_id_npc;
            rdat1_q <= rdat1_d;
            rdat2_q <= rdat2_d;
            sext_q  <= sext_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

    assign illegal_o              = ill_q;
    assign id_ex_wb               = wb_q;
    assign id_ex_mem              = mem_q;
    assign id_ex_execute          = ex_q;
    assign id_ex_npc              = npc_q;
    assign id_ex_readdat1         = rdat1_q;
    assign id_ex_readdat2         = rdat2_q;
    assign id_ex_sign_ext         = sext_q;
    assign id_ex_instr_bits_25_21 = rs_q;
    assign id_ex_instr_bits_20_16 = rt_q;
    assign id_ex_instr_bits_15_11 = rd_q;

endmodule
